reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port register file with clocked write, optional write->read
//  bypass, optional hardwired-zero r0, gated overflow flag and per-register pending
//  (scoreboard) bits. Sits between decode and execute of the custom-ISA datapath; it
//  serves NR operand reads per cycle and flags operands whose producer has not written back.
// PARAMETERS
//  W       8   data width (bits)
//  D       4   address width; 2**D registers
//  NR      2   number of combinational read ports (1..4)
//  ACC     0   register index driven on Readacc (accumulator tap)
//  ZERO_R0 0   1: register 0 reads 0, writes to it dropped, never pending
//  BYPASS  1   1: same-cycle writeback forwarded to read ports and busy flags
// PORTS
//  CLK         in   1       clock, all state on posedge
//  Reset       in   1       synchronous, active-high
//  RegWrite    in   1       writeback enable
//  writeSrc    in   D       writeback register index
//  writeValue  in   W       writeback data
//  OvWrite     in   1       overflow flag update enable
//  Writeov     in   1       overflow flag next value
//  Issue       in   1       mark issueDst pending (instruction issued)
//  issueDst    in   D       destination register of issued instruction
//  src         in   NR*D    read addresses, port i = src[i*D +: D]
//  Read        out  NR*W    read data, port i = Read[i*W +: W]
//  Busy        out  NR      port i operand still pending
//  Readacc     out  W       contents of register ACC
//  Readov      out  1       overflow flag
//  AnyBusy     out  1       OR of all pending bits
// BEHAVIOUR
//  Reset (sampled on posedge): all registers <= 0, ov <= 0, pending <= 0. Reset has
//   priority; RegWrite/OvWrite/Issue in a reset cycle are dropped. Outputs after reset:
//   Read=0, Busy=0, Readacc=0, Readov=0, AnyBusy=0.
//  Write: RegWrite=1 -> core[writeSrc] <= writeValue at posedge; visible next cycle
//   (BYPASS=0) or same cycle combinationally (BYPASS=1). ZERO_R0=1 and writeSrc=0 -> dropped.
//  Reads: combinational, zero latency. Read[i] = (BYPASS && RegWrite && writeSrc==src_i
//   && !(ZERO_R0 && src_i==0)) ? writeValue : core[src_i]; ZERO_R0 && src_i==0 -> 0.
//   All ports independent; any port may alias any other.
//  Readacc = core[ACC] (no bypass; registered value only). ZERO_R0 && ACC==0 -> 0.
//  Overflow: ov <= Writeov only when OvWrite=1, else holds. Readov = ov (no bypass).
//  Pending state, per register, updated at posedge (non-reset):
//   RegWrite -> clear pending[writeSrc]; Issue -> set pending[issueDst].
//   Same register both events same cycle -> set wins (newer producer outstanding).
//   Issue with ZERO_R0 && issueDst==0 -> ignored. Issue to pending reg -> stays set.
//  Busy[i] = pending[src_i], except BYPASS=1 and RegWrite && writeSrc==src_i -> 0
//   (value is being forwarded). Busy does not see same-cycle Issue.
//  AnyBusy = |pending (registered state only).
//  Widths: no arithmetic; indices exactly D bits, so all 2**D registers addressable, no wrap.
//  Unknown-free: all state reset; no X on outputs after first reset cycle.
// TESTING
//  1 Reset: preload r3=0x5A, assert Reset one cycle with RegWrite r3=0xFF -> r3 reads 0,
//    Readov=0, AnyBusy=0.
//  2 Write/read all: write r[k]=k*0x11 for k=0..15, read via port0/port1 k and 15-k ->
//    exact values; with BYPASS=1 the write cycle already shows the new value on a matching
//    port, with BYPASS=0 only the next cycle.
//  3 ZERO_R0=1: write r0=0xAB, Issue r0 -> Read r0=0, Busy=0, AnyBusy=0; ZERO_R0=0 same
//    stimulus -> r0=0xAB.
//  4 Scoreboard: Issue r5; next cycle src0=5 -> Busy[0]=1, AnyBusy=1; RegWrite r5=0x33 ->
//    same cycle Busy[0]=0 and Read=0x33 (BYPASS=1); next cycle AnyBusy=0.
//  5 Collision: r7 pending, same cycle Issue r7 + RegWrite r7=0x10 -> r7=0x10, pending[7]
//    stays 1; Reset mid-flight with r2,r7 pending -> all pending cleared.
//  6 Overflow/acc: OvWrite=1 Writeov=1 -> Readov=1 next cycle; OvWrite=0 Writeov=0 ->
//    Readov stays 1; ACC=3, write r3=0x7E -> Readacc=0x7E next cycle, not same cycle.

Source files
------------

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp_if
// Description : Operand/writeback bus between decode/execute and reg_file_mp.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_mp_if #(
   parameter int W  = 8,
   parameter int D  = 4,
   parameter int NR = 2
);
   logic            RegWrite;
   logic [D-1:0]    writeSrc;
   logic [W-1:0]    writeValue;
   logic            OvWrite;
   logic            Writeov;
   logic            Issue;
   logic [D-1:0]    issueDst;
   logic [NR*D-1:0] src;
   logic [NR*W-1:0] Read;
   logic [NR-1:0]   Busy;
   logic [W-1:0]    Readacc;
   logic            Readov;
   logic            AnyBusy;

   modport master (
      output RegWrite, writeSrc, writeValue, OvWrite, Writeov, Issue, issueDst, src,
      input  Read, Busy, Readacc, Readov, AnyBusy
   );

   modport slave (
      input  RegWrite, writeSrc, writeValue, OvWrite, Writeov, Issue, issueDst, src,
      output Read, Busy, Readacc, Readov, AnyBusy
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-read-port register file with optional write bypass,
//               hardwired r0, overflow flag and per-register pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
   parameter int W       = 8,
   parameter int D       = 4,
   parameter int NR      = 2,
   parameter int ACC     = 0,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  wire logic      CLK,
   input  wire logic      Reset,
   reg_file_mp_if.slave   bus
);
   localparam int           c_NREG = 2 ** D;
   localparam bit           c_ZERO = (ZERO_R0 != 0);
   localparam bit           c_BYP  = (BYPASS != 0);
   localparam logic [D-1:0] c_ACC  = D'(ACC);

   logic [W-1:0]      r_core [c_NREG];
   logic              r_ov;
   logic [c_NREG-1:0] r_pending;

   logic              w_wr_en;
   logic              w_iss_en;
   logic [D-1:0]      w_addr;
   logic              w_zero;
   logic              w_fwd;
   logic [NR*W-1:0]   w_read;
   logic [NR-1:0]     w_busy;

   assign w_wr_en  = bus.RegWrite && !(c_ZERO && (bus.writeSrc == '0));
   assign w_iss_en = bus.Issue    && !(c_ZERO && (bus.issueDst == '0));

   // Issue is applied after the writeback clear so a same-register collision leaves it pending.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int k = 0; k < c_NREG; k++) begin
            r_core[k] <= '0;
         end
         r_ov      <= 1'b0;
         r_pending <= '0;
      end else begin
         if (w_wr_en) begin
            r_core[bus.writeSrc] <= bus.writeValue;
         end
         if (bus.OvWrite) begin
            r_ov <= bus.Writeov;
         end
         if (bus.RegWrite) begin
            r_pending[bus.writeSrc] <= 1'b0;
         end
         if (w_iss_en) begin
            r_pending[bus.issueDst] <= 1'b1;
         end
      end
   end

   always_comb begin
      w_read = '0;
      w_busy = '0;
      w_addr = '0;
      w_zero = 1'b0;
      w_fwd  = 1'b0;
      for (int i = 0; i < NR; i++) begin
         w_addr = bus.src[i*D +: D];
         w_zero = c_ZERO && (w_addr == '0);
         w_fwd  = c_BYP && bus.RegWrite && (bus.writeSrc == w_addr) && !w_zero;
         if (w_zero) begin
            w_read[i*W +: W] = '0;
         end else if (w_fwd) begin
            w_read[i*W +: W] = bus.writeValue;
         end else begin
            w_read[i*W +: W] = r_core[w_addr];
         end
         // A forwarded operand is by definition no longer outstanding.
         w_busy[i] = w_fwd ? 1'b0 : r_pending[w_addr];
      end
   end

   assign bus.Read    = w_read;
   assign bus.Busy    = w_busy;
   assign bus.Readacc = (c_ZERO && (c_ACC == '0)) ? '0 : r_core[c_ACC];
   assign bus.Readov  = r_ov;
   assign bus.AnyBusy = |r_pending;
endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed bench; dut_a = bypass, ACC=3; dut_b = no bypass, zero r0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;
   logic CLK = 1'b0;
   logic Reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 CLK = ~CLK;

   reg_file_mp_if #(.W(8), .D(4), .NR(2)) ifa ();
   reg_file_mp_if #(.W(8), .D(4), .NR(2)) ifb ();

   assign ifb.RegWrite   = ifa.RegWrite;
   assign ifb.writeSrc   = ifa.writeSrc;
   assign ifb.writeValue = ifa.writeValue;
   assign ifb.OvWrite    = ifa.OvWrite;
   assign ifb.Writeov    = ifa.Writeov;
   assign ifb.Issue      = ifa.Issue;
   assign ifb.issueDst   = ifa.issueDst;
   assign ifb.src        = ifa.src;

   reg_file_mp #(.W(8), .D(4), .NR(2), .ACC(3), .ZERO_R0(0), .BYPASS(1)) dut_a (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (ifa)
   );

   reg_file_mp #(.W(8), .D(4), .NR(2), .ACC(0), .ZERO_R0(1), .BYPASS(0)) dut_b (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (ifb)
   );

   typedef struct {
      logic       rst, wr;
      logic [3:0] ws;
      logic [7:0] wv;
      logic       iss;
      logic [3:0] id;
      logic       ovw, ovv;
      logic [3:0] s0, s1;
      logic [7:0] ar0, ar1;
      logic [1:0] ab;
      logic       aany;
      logic [7:0] aacc;
      logic       aov;
      logic [7:0] br0, br1;
      logic [1:0] bb;
      logic       bany;
      logic [7:0] bacc;
      logic       bov;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, wr, input logic [3:0] ws, input logic [7:0] wv,
                      input logic iss, input logic [3:0] id, input logic ovw, ovv,
                      input logic [3:0] s0, s1,
                      input logic [7:0] ar0, ar1, input logic [1:0] ab, input logic aany,
                      input logic [7:0] aacc, input logic aov,
                      input logic [7:0] br0, br1, input logic [1:0] bb, input logic bany,
                      input logic [7:0] bacc, input logic bov);
      vec_t v;
      v.rst = rst; v.wr = wr; v.ws = ws; v.wv = wv; v.iss = iss; v.id = id;
      v.ovw = ovw; v.ovv = ovv; v.s0 = s0; v.s1 = s1;
      v.ar0 = ar0; v.ar1 = ar1; v.ab = ab; v.aany = aany; v.aacc = aacc; v.aov = aov;
      v.br0 = br0; v.br1 = br1; v.bb = bb; v.bany = bany; v.bacc = bacc; v.bov = bov;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, wr, input logic [3:0] ws, input logic [7:0] wv,
                        input logic iss, input logic [3:0] id, input logic ovw, ovv,
                        input logic [3:0] s0, s1);
      Reset          = rst;
      ifa.RegWrite   = wr;
      ifa.writeSrc   = ws;
      ifa.writeValue = wv;
      ifa.Issue      = iss;
      ifa.issueDst   = id;
      ifa.OvWrite    = ovw;
      ifa.Writeov    = ovv;
      ifa.src        = {s1, s0};
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Test 2: walk writes; dut_a forwards on port 0, dut_b shows old contents.
      add(0,1, 0,8'h00,0,0,0,0, 0,15, 8'h00,8'h00,2'b00,0,8'h00,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 1,8'h11,0,0,0,0, 1,14, 8'h11,8'h00,2'b00,0,8'h00,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 2,8'h22,0,0,0,0, 2,13, 8'h22,8'h00,2'b00,0,8'h00,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 3,8'h33,0,0,0,0, 3,12, 8'h33,8'h00,2'b00,0,8'h00,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 4,8'h44,0,0,0,0, 4,11, 8'h44,8'h00,2'b00,0,8'h33,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 5,8'h55,0,0,0,0, 5,10, 8'h55,8'h00,2'b00,0,8'h33,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 6,8'h66,0,0,0,0, 6, 9, 8'h66,8'h00,2'b00,0,8'h33,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 7,8'h77,0,0,0,0, 7, 8, 8'h77,8'h00,2'b00,0,8'h33,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,1, 8,8'h88,0,0,0,0, 8, 7, 8'h88,8'h77,2'b00,0,8'h33,0, 8'h00,8'h77,2'b00,0,8'h00,0);
      add(0,1, 9,8'h99,0,0,0,0, 9, 6, 8'h99,8'h66,2'b00,0,8'h33,0, 8'h00,8'h66,2'b00,0,8'h00,0);
      add(0,1,10,8'hAA,0,0,0,0,10, 5, 8'hAA,8'h55,2'b00,0,8'h33,0, 8'h00,8'h55,2'b00,0,8'h00,0);
      add(0,1,11,8'hBB,0,0,0,0,11, 4, 8'hBB,8'h44,2'b00,0,8'h33,0, 8'h00,8'h44,2'b00,0,8'h00,0);
      add(0,1,12,8'hCC,0,0,0,0,12, 3, 8'hCC,8'h33,2'b00,0,8'h33,0, 8'h00,8'h33,2'b00,0,8'h00,0);
      add(0,1,13,8'hDD,0,0,0,0,13, 2, 8'hDD,8'h22,2'b00,0,8'h33,0, 8'h00,8'h22,2'b00,0,8'h00,0);
      add(0,1,14,8'hEE,0,0,0,0,14, 1, 8'hEE,8'h11,2'b00,0,8'h33,0, 8'h00,8'h11,2'b00,0,8'h00,0);
      add(0,1,15,8'hFF,0,0,0,0,15, 0, 8'hFF,8'h00,2'b00,0,8'h33,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 0,15, 8'h00,8'hFF,2'b00,0,8'h33,0, 8'h00,8'hFF,2'b00,0,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 5,10, 8'h55,8'hAA,2'b00,0,8'h33,0, 8'h55,8'hAA,2'b00,0,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0,15,15, 8'hFF,8'hFF,2'b00,0,8'h33,0, 8'hFF,8'hFF,2'b00,0,8'h00,0);
      // Test 3: write + issue to r0.
      add(0,1, 0,8'hAB,1,0,0,0, 0, 0, 8'hAB,8'hAB,2'b00,0,8'h33,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 0, 1, 8'hAB,8'h11,2'b01,1,8'h33,0, 8'h00,8'h11,2'b00,0,8'h00,0);
      add(0,1, 0,8'hAB,0,0,0,0, 0, 2, 8'hAB,8'h22,2'b00,1,8'h33,0, 8'h00,8'h22,2'b00,0,8'h00,0);
      // Test 4: scoreboard on r5.
      add(0,0, 0,8'h00,1,5,0,0, 5, 6, 8'h55,8'h66,2'b00,0,8'h33,0, 8'h55,8'h66,2'b00,0,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 5, 5, 8'h55,8'h55,2'b11,1,8'h33,0, 8'h55,8'h55,2'b11,1,8'h00,0);
      add(0,1, 5,8'h33,0,0,0,0, 5, 4, 8'h33,8'h44,2'b00,1,8'h33,0, 8'h55,8'h44,2'b01,1,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 5, 5, 8'h33,8'h33,2'b00,0,8'h33,0, 8'h33,8'h33,2'b00,0,8'h00,0);
      // Test 5: issue/writeback collision on r7, then reset with r2,r7 pending.
      add(0,0, 0,8'h00,1,7,0,0, 7, 2, 8'h77,8'h22,2'b00,0,8'h33,0, 8'h77,8'h22,2'b00,0,8'h00,0);
      add(0,1, 7,8'h10,1,7,0,0, 7, 7, 8'h10,8'h10,2'b00,1,8'h33,0, 8'h77,8'h77,2'b11,1,8'h00,0);
      add(0,0, 0,8'h00,1,2,0,0, 7, 2, 8'h10,8'h22,2'b01,1,8'h33,0, 8'h10,8'h22,2'b01,1,8'h00,0);
      add(1,0, 0,8'h00,0,0,0,0, 7, 2, 8'h10,8'h22,2'b11,1,8'h33,0, 8'h10,8'h22,2'b11,1,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 7, 2, 8'h00,8'h00,2'b00,0,8'h00,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      // Test 6: overflow flag and accumulator tap.
      add(0,1, 3,8'h7E,0,0,1,1, 3, 0, 8'h7E,8'h00,2'b00,0,8'h00,0, 8'h00,8'h00,2'b00,0,8'h00,0);
      add(0,0, 0,8'h00,0,0,0,0, 3, 3, 8'h7E,8'h7E,2'b00,0,8'h7E,1, 8'h7E,8'h7E,2'b00,0,8'h00,1);
      add(0,0, 0,8'h00,0,0,1,0, 0, 0, 8'h00,8'h00,2'b00,0,8'h7E,1, 8'h00,8'h00,2'b00,0,8'h00,1);
      add(0,0, 0,8'h00,0,0,0,0, 0, 0, 8'h00,8'h00,2'b00,0,8'h7E,0, 8'h00,8'h00,2'b00,0,8'h00,0);

      // Power-up reset.
      drive(1,0,0,8'h00,0,0,0,0,0,0);
      tick();
      tick();
      drive(0,0,0,8'h00,0,0,0,0,3,4);
      @(negedge CLK);
      chk("por.a.read0",   ifa.Read[7:0],  0);
      chk("por.a.anybusy", ifa.AnyBusy,    0);
      chk("por.b.read1",   ifb.Read[15:8], 0);
      tick();

      // Test 1: preload r3, then reset while writing r3 and issuing r4.
      drive(0,1,3,8'h5A,0,0,0,0,3,4);
      tick();
      drive(1,1,3,8'hFF,1,4,1,1,3,4);
      @(negedge CLK);
      chk("t1.a.acc_preload", ifa.Readacc, 8'h5A);
      chk("t1.b.read0_preload", ifb.Read[7:0], 8'h5A);
      tick();
      drive(0,0,0,8'h00,0,0,0,0,3,4);
      @(negedge CLK);
      chk("t1.a.read0",   ifa.Read[7:0], 0);
      chk("t1.b.read0",   ifb.Read[7:0], 0);
      chk("t1.a.acc",     ifa.Readacc,   0);
      chk("t1.a.ov",      ifa.Readov,    0);
      chk("t1.b.ov",      ifb.Readov,    0);
      chk("t1.a.anybusy", ifa.AnyBusy,   0);
      chk("t1.b.busy",    ifb.Busy,      0);
      tick();

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].wr, vecs[i].ws, vecs[i].wv, vecs[i].iss, vecs[i].id,
               vecs[i].ovw, vecs[i].ovv, vecs[i].s0, vecs[i].s1);
         @(negedge CLK);
         chk($sformatf("v%0d.a.read0", i),   ifa.Read[7:0],  vecs[i].ar0);
         chk($sformatf("v%0d.a.read1", i),   ifa.Read[15:8], vecs[i].ar1);
         chk($sformatf("v%0d.a.busy", i),    ifa.Busy,       vecs[i].ab);
         chk($sformatf("v%0d.a.anybusy", i), ifa.AnyBusy,    vecs[i].aany);
         chk($sformatf("v%0d.a.acc", i),     ifa.Readacc,    vecs[i].aacc);
         chk($sformatf("v%0d.a.ov", i),      ifa.Readov,     vecs[i].aov);
         chk($sformatf("v%0d.b.read0", i),   ifb.Read[7:0],  vecs[i].br0);
         chk($sformatf("v%0d.b.read1", i),   ifb.Read[15:8], vecs[i].br1);
         chk($sformatf("v%0d.b.busy", i),    ifb.Busy,       vecs[i].bb);
         chk($sformatf("v%0d.b.anybusy", i), ifb.AnyBusy,    vecs[i].bany);
         chk($sformatf("v%0d.b.acc", i),     ifb.Readacc,    vecs[i].bacc);
         chk($sformatf("v%0d.b.ov", i),      ifb.Readov,     vecs[i].bov);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
